// File: rtl/uart_line_ctrl.sv
// Line assembler behind the UART receiver: buffers bytes up to a terminator,
// then replays the finished line on a valid/ready stream with status flags.
module uart_line_ctrl #(
    parameter int         MAX_LEN     = 32,
    parameter logic [7:0] TERM_CHAR   = 8'h0D,
    parameter int         TIMEOUT_CYC = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       start_pulse,
    input  logic       framing_error,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] line_len,
    output logic       eos,
    output logic [3:0] err_flags,
    input  logic       err_clr
);

    localparam int AW = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);
    localparam bit TO_EN = TIMEOUT_CYC > 0;
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] IDLE_LAST =
        IW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    // err_flags bit positions
    localparam int E_FRAME   = 0;
    localparam int E_OVERFL  = 1;
    localparam int E_OVERRUN = 2;
    localparam int E_TIMEOUT = 3;

    typedef enum logic [1:0] {
        COLLECT,
        DISCARD,
        DRAIN
    } state_t;

    state_t        state;
    logic [7:0]    count;
    logic [7:0]    rd_ptr;
    logic [IW-1:0] idle;
    logic [7:0]    line_buf [MAX_LEN];

    logic       is_term;
    logic       wr_en;
    logic [7:0] nxt_ptr;

    assign is_term = (rx_byte == TERM_CHAR);
    assign nxt_ptr = rd_ptr + 8'd1;

    assign wr_en = (state == COLLECT) && !framing_error && rx_valid
                && !is_term && (count < MAX_CNT);

    // Storage has no reset: count gates every read, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[count[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= COLLECT;
            count     <= 8'd0;
            rd_ptr    <= 8'd0;
            idle      <= '0;
            line_len  <= 8'd0;
            eos       <= 1'b0;
            err_flags <= 4'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'd0;
        end else begin
            // Clears come first so a coincident set below wins.
            if (start_pulse) begin
                eos <= 1'b0;
            end
            if (err_clr) begin
                err_flags <= 4'b0;
            end

            unique case (state)
                COLLECT: begin
                    if (framing_error) begin
                        err_flags[E_FRAME] <= 1'b1;
                        idle               <= '0;
                        state              <= DISCARD;
                    end else if (rx_valid) begin
                        idle <= '0;
                        if (!is_term) begin
                            if (count < MAX_CNT) begin
                                count <= count + 8'd1;
                            end else begin
                                err_flags[E_OVERFL] <= 1'b1;
                                state               <= DISCARD;
                            end
                        end else if (count != 8'd0) begin
                            line_len  <= count;
                            eos       <= 1'b1;
                            rd_ptr    <= 8'd0;
                            out_valid <= 1'b1;
                            out_byte  <= line_buf[0];
                            out_last  <= (count == 8'd1);
                            state     <= DRAIN;
                        end
                    end else if (TO_EN && count != 8'd0) begin
                        if (idle == IDLE_LAST) begin
                            err_flags[E_TIMEOUT] <= 1'b1;
                            count                <= 8'd0;
                            idle                 <= '0;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                end

                DISCARD: begin
                    if (rx_valid && is_term) begin
                        count <= 8'd0;
                        state <= COLLECT;
                    end
                end

                DRAIN: begin
                    if (rx_valid || framing_error) begin
                        err_flags[E_OVERRUN] <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            count     <= 8'd0;
                            rd_ptr    <= 8'd0;
                            state     <= COLLECT;
                        end else begin
                            rd_ptr   <= nxt_ptr;
                            out_byte <= line_buf[nxt_ptr[AW-1:0]];
                            out_last <= (nxt_ptr == line_len - 8'd1);
                        end
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_ctrl.sv
// Bench for uart_line_ctrl: line-level table, corner sequences and random
// traffic checked every cycle against a queue-based line model.
module tb_uart_line_ctrl;

    localparam int         MAXL = 4;
    localparam int         TO   = 100;
    localparam logic [7:0] TERM = 8'h0D;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       start_pulse = 1'b0;
    logic       framing_error = 1'b0;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic [7:0] line_len;
    logic       eos;
    logic [3:0] err_flags;
    logic       err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    string emitted = "";

    uart_line_ctrl #(
        .MAX_LEN    (MAXL),
        .TERM_CHAR  (TERM),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .start_pulse  (start_pulse),
        .framing_error(framing_error),
        .out_valid    (out_valid),
        .out_byte     (out_byte),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .line_len     (line_len),
        .eos          (eos),
        .err_flags    (err_flags),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: partial line and line-being-replayed as queues.
    logic [7:0] pend[$];
    logic [7:0] outq[$];
    bit         disc = 1'b0;
    int         idle_n = 0;
    logic [7:0] m_len = 8'd0;
    bit         m_eos = 1'b0;
    logic [3:0] m_err = 4'b0;

    always @(posedge clk) begin
        bit         eset;
        logic [3:0] es;
        eset = 1'b0;
        es = 4'b0;
        if (!rstn) begin
            pend.delete();
            outq.delete();
            disc = 1'b0;
            idle_n = 0;
            m_len = 8'd0;
            m_eos = 1'b0;
            m_err = 4'b0;
        end else begin
            if (outq.size() > 0) begin
                if (rx_valid || framing_error) es[2] = 1'b1;
                if (out_ready) void'(outq.pop_front());
                idle_n = 0;
            end else if (disc) begin
                if (rx_valid && rx_byte == TERM) begin
                    disc = 1'b0;
                    pend.delete();
                end
                idle_n = 0;
            end else if (framing_error) begin
                es[0] = 1'b1;
                disc = 1'b1;
                idle_n = 0;
            end else if (rx_valid) begin
                idle_n = 0;
                if (rx_byte != TERM) begin
                    if (pend.size() < MAXL) begin
                        pend.push_back(rx_byte);
                    end else begin
                        es[1] = 1'b1;
                        disc = 1'b1;
                    end
                end else if (pend.size() > 0) begin
                    outq = pend;
                    m_len = 8'(pend.size());
                    eset = 1'b1;
                    pend.delete();
                end
            end else if (pend.size() > 0) begin
                idle_n++;
                if (idle_n == TO) begin
                    es[3] = 1'b1;
                    pend.delete();
                    idle_n = 0;
                end
            end
            m_eos = eset ? 1'b1 : (start_pulse ? 1'b0 : m_eos);
            m_err = (err_clr ? 4'b0 : m_err) | es;
        end
    end

    always @(negedge clk) begin
        bit         ev;
        bit         el;
        logic [7:0] eb;
        if (chk_en) begin
            ev = outq.size() > 0;
            el = outq.size() == 1;
            eb = ev ? outq[0] : out_byte;
            total++;
            if (out_valid !== ev || out_last !== el || out_byte !== eb
                || line_len !== m_len || eos !== m_eos
                || err_flags !== m_err) begin
                bad++;
                $display("FAIL model t=%0t got v%b b%h l%b len%0d e%b err%b want v%b b%h l%b len%0d e%b err%b",
                         $time, out_valid, out_byte, out_last, line_len,
                         eos, err_flags, ev, eb, el, m_len, m_eos, m_err);
            end
        end
    end

    always @(posedge clk) begin
        if (rstn && out_valid && out_ready) begin
            emitted = {emitted, $sformatf("%c", out_byte)};
            if (out_last) emitted = {emitted, "|"};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chks(input string nm, input string act,
                        input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got '%s' want '%s'", nm, act, exp);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (out_valid && k < 200) begin
            tick();
            k++;
        end
        chk("drain_bound", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rx_valid = 1'b0;
        framing_error = 1'b0;
        start_pulse = 1'b0;
        err_clr = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        emitted = "";
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send((s[i] == "#") ? TERM : s[i]);
            tick();
            if (s[i] == "#") wait_drain();
        end
    endtask

    typedef struct {
        string      name;
        string      stim;
        int         fe_at;
        string      exp_out;
        logic [3:0] exp_err;
        bit         exp_eos;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit held;

        vecs[0] = '{"ab",      "AB#",       -1, "AB|",   4'b0000, 1'b1};
        vecs[1] = '{"lone_cr", "#",         -1, "",      4'b0000, 1'b0};
        vecs[2] = '{"ovfl",    "ABCDE#XY#", -1, "XY|",   4'b0010, 1'b1};
        vecs[3] = '{"frame",   "ABC#OK#",    2, "OK|",   4'b0001, 1'b1};
        vecs[4] = '{"full",    "ABCD#",     -1, "ABCD|", 4'b0000, 1'b1};
        vecs[5] = '{"empties", "##Q#A#",    -1, "Q|A|",  4'b0000, 1'b1};

        do_reset();
        chk_en = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_eos", 32'(eos), 32'd0);
        chk("rst_len", 32'(line_len), 32'd0);

        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < vecs[v].stim.len(); i++) begin
                if (i == vecs[v].fe_at) begin
                    framing_error = 1'b1;
                    tick();
                    framing_error = 1'b0;
                    tick();
                end
                send((vecs[v].stim[i] == "#") ? TERM : vecs[v].stim[i]);
                tick();
                if (vecs[v].stim[i] == "#") wait_drain();
            end
            tick();
            chks({vecs[v].name, "_out"}, emitted, vecs[v].exp_out);
            chk({vecs[v].name, "_err"}, 32'(err_flags),
                32'(vecs[v].exp_err));
            chk({vecs[v].name, "_eos"}, 32'(eos), 32'(vecs[v].exp_eos));
        end

        // eos clear, then set beating a coincident clear
        do_reset();
        send_str("AB#");
        chk("ab_len", 32'(line_len), 32'd2);
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk("eos_clr", 32'(eos), 32'd0);
        send("C");
        tick();
        start_pulse = 1'b1;
        send(TERM);
        start_pulse = 1'b0;
        chk("eos_set_wins", 32'(eos), 32'd1);
        wait_drain();

        // err_clr alone, then coincident with a new frame error
        do_reset();
        framing_error = 1'b1;
        tick();
        framing_error = 1'b0;
        chk("fe_set", 32'(err_flags), 32'h1);
        send(TERM);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", 32'(err_flags), 32'h0);
        err_clr = 1'b1;
        framing_error = 1'b1;
        tick();
        err_clr = 1'b0;
        framing_error = 1'b0;
        chk("err_set_wins", 32'(err_flags), 32'h1);

        // stalled consumer with a byte arriving mid-drain
        do_reset();
        out_ready = 1'b0;
        send("H");
        tick();
        send("I");
        tick();
        send(TERM);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_byte", 32'(out_byte), 32'h48);
        held = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) send("Z");
            else tick();
            if (!out_valid || out_byte != 8'h48 || out_last) held = 1'b0;
        end
        chk("stall_hold", 32'(held), 32'd1);
        chk("overrun", 32'(err_flags), 32'h4);
        out_ready = 1'b1;
        wait_drain();
        tick();
        chks("stall_out", emitted, "HI|");

        // idle timeout boundary: 100 idle cycles drop, 99 keep
        do_reset();
        send("A");
        idle(TO);
        send("B");
        tick();
        send(TERM);
        wait_drain();
        tick();
        chk("timeout_err", 32'(err_flags), 32'h8);
        chks("timeout_out", emitted, "B|");
        do_reset();
        send("A");
        idle(TO - 1);
        send("B");
        send(TERM);
        wait_drain();
        tick();
        chk("no_timeout_err", 32'(err_flags), 32'h0);
        chks("no_timeout_out", emitted, "AB|");

        // reset in the middle of a drain
        do_reset();
        out_ready = 1'b0;
        send("H");
        send("I");
        send(TERM);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_eos", 32'(eos), 32'd0);
        chk("mid_rst_len", 32'(line_len), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int pick;
            rstn = ($urandom_range(0, 399) != 0);
            rx_valid = ($urandom_range(0, 9) < 3);
            pick = $urandom_range(0, 3);
            rx_byte = (pick == 0) ? TERM : 8'(8'h40 + pick);
            start_pulse = ($urandom_range(0, 19) == 0);
            framing_error = ($urandom_range(0, 59) == 0);
            err_clr = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b1;
                rx_valid = 1'b0;
                start_pulse = 1'b0;
                framing_error = 1'b0;
                err_clr = 1'b0;
                idle($urandom_range(TO - 5, TO + 5));
            end
        end

        rstn = 1'b1;
        rx_valid = 1'b0;
        framing_error = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
